// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: register-bus initiator driven by the SPI byte shifter.
// It decodes a command byte and then the data or dummy bytes of one chip-select frame
// into single-cycle read/write strobes on the PWM register block. Read data is returned
// to the shifter through tx_data/tx_load. Bursts auto-increment the address (mod 64)
// when AUTO_INC is set.
//
// Ports:
//   clk, rst          peripheral clock, synchronous active-high reset
//   frame_active      SPI chip select asserted
//   byte_valid        byte_in holds a complete received byte (one-cycle pulse)
//   byte_in           received byte
//   tx_data, tx_load  byte for the shifter, with a one-cycle latch pulse
//   overrun           byte arrived while a read was still in flight (one-cycle pulse)
//   read, write       one-cycle register strobes
//   addr, data_write  register address and write data (hold between strobes)
//   data_read         register read data, valid READ_LAT cycles after the read strobe
module spi_cmd_decoder #(
  parameter bit          AUTO_INC = 1'b1,
  parameter int unsigned READ_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_active,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  output logic [7:0] tx_data,
  output logic       tx_load,
  output logic       overrun,
  output logic       read,
  output logic       write,
  output logic [5:0] addr,
  output logic [7:0] data_write,
  input  logic [7:0] data_read
);

  localparam int unsigned CntW = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StWrData,
    StRdIssue,
    StRdWait,
    StRdShift
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] lat_cnt_q;
  logic            rd_pend_q;
  logic            lat_done;

  // Read data is due on the bus this cycle.
  assign lat_done = rd_pend_q && (lat_cnt_q == CntW'(READ_LAT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      lat_cnt_q  <= '0;
      rd_pend_q  <= 1'b0;
      read       <= 1'b0;
      write      <= 1'b0;
      tx_load    <= 1'b0;
      overrun    <= 1'b0;
      addr       <= 6'h00;
      data_write <= 8'h00;
      tx_data    <= 8'h00;
    end else begin
      read    <= 1'b0;
      write   <= 1'b0;
      tx_load <= 1'b0;
      overrun <= 1'b0;

      // Post-increment at the end of the write cycle; a write issued on this same edge
      // therefore already sees the new address.
      if (AUTO_INC && write) begin
        addr <= addr + 6'd1;
      end

      // Latency tracking runs independently of the state so a read aborted by a frame
      // drop still completes its capture (tx_load is then suppressed below).
      if (rd_pend_q) begin
        if (lat_done) begin
          tx_data   <= data_read;
          rd_pend_q <= 1'b0;
        end else begin
          lat_cnt_q <= lat_cnt_q + 1'b1;
        end
      end

      if (!frame_active) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: state_q <= StCmd;

          StCmd: begin
            if (byte_valid) begin
              addr    <= byte_in[5:0];
              state_q <= byte_in[7] ? StWrData : StRdIssue;
            end
          end

          StWrData: begin
            if (byte_valid) begin
              data_write <= byte_in;
              write      <= 1'b1;
            end
          end

          StRdIssue: begin
            read      <= 1'b1;
            rd_pend_q <= 1'b1;
            lat_cnt_q <= '0;
            state_q   <= StRdWait;
            if (byte_valid) begin
              overrun <= 1'b1;
            end
          end

          StRdWait: begin
            if (byte_valid) begin
              overrun <= 1'b1;
            end
            if (lat_done) begin
              tx_load <= 1'b1;
              state_q <= StRdShift;
            end
          end

          StRdShift: begin
            // Dummy byte clocked in by the master: fetch the next register.
            if (byte_valid) begin
              if (AUTO_INC) begin
                addr <= addr + 6'd1;
              end
              state_q <= StRdIssue;
            end
          end

          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
